// File: rtl/round_robin_arbiter_v2.sv
// Registered round-robin arbiter: rotating-priority grant, one-cycle latency.
// Defining RR_GRANT_IDX_EN adds registered grant_valid_o / grant_idx_o outputs.
module round_robin_arbiter_v2 #(
    parameter int REQUIRE_NUM = 4
) (
    input  logic                           sys_clk_i,
    input  logic                           rst_i,
    input  logic [REQUIRE_NUM-1:0]         request_i,
    output logic [REQUIRE_NUM-1:0]         respond_o
`ifdef RR_GRANT_IDX_EN
    ,
    output logic                           grant_valid_o,
    output logic [$clog2(REQUIRE_NUM)-1:0] grant_idx_o
`endif
);

    localparam int PTR_W = $clog2(REQUIRE_NUM);

    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic [PTR_W:0]         cand_ext;
    logic [PTR_W-1:0]       cand;
    logic                   found;
    logic [REQUIRE_NUM-1:0] grant_next;

    // Scan from ptr upward with wrap-around; the extra cand_ext bit keeps
    // ptr+i from overflowing before the wrap is applied.
    // NOTE: every variable gets a default before the loop so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        found      = 1'b0;
        win_idx    = '0;
        cand_ext   = '0;
        cand       = '0;
        grant_next = '0;
        for (int i = 0; i < REQUIRE_NUM; i++) begin
            cand_ext = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand_ext >= (PTR_W+1)'(REQUIRE_NUM))
                cand_ext = cand_ext - (PTR_W+1)'(REQUIRE_NUM);
            cand = cand_ext[PTR_W-1:0];
            if (!found && request_i[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (found)
            grant_next[win_idx] = 1'b1;
    end

    assign next_ptr = (win_idx == PTR_W'(REQUIRE_NUM - 1)) ? '0 : win_idx + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            respond_o <= '0;
            ptr       <= '0;
        end else begin
            respond_o <= grant_next;
            if (found)
                ptr <= next_ptr;
        end
    end

`ifdef RR_GRANT_IDX_EN
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_valid_o <= 1'b0;
            grant_idx_o   <= '0;
        end else begin
            grant_valid_o <= found;
            grant_idx_o   <= win_idx;
        end
    end
`endif

endmodule

// File: tb/tb_round_robin_arbiter_v2.sv
// Directed and randomized self-checking bench for round_robin_arbiter_v2 (4 requesters).
module tb_round_robin_arbiter_v2;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] request;
    logic [N-1:0] respond;
`ifdef RR_GRANT_IDX_EN
    logic         grant_valid;
    logic [1:0]   grant_idx;
`endif

    int vectors     = 0;
    int miscompares = 0;

    round_robin_arbiter_v2 #(.REQUIRE_NUM(N)) dut (
        .sys_clk_i     (clk),
        .rst_i         (rst),
        .request_i     (request),
        .respond_o     (respond)
`ifdef RR_GRANT_IDX_EN
        ,
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge: drive, let the DUT sample, then check.
    task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] exp, input string tag);
        request = req;
        @(posedge clk);
        @(negedge clk);
        check(tag, 32'(respond), 32'(exp));
    endtask

    initial begin
        logic [N-1:0] req_r;
        logic [N-1:0] prev;
        logic [N-1:0] exp_g;
        int           ptr_m;
        int           g;
        int           idx;
        int           max_wait;
        int           wait_c [N];

        rst     = 1'b0;
        request = '0;
        #2 rst = 1'b1;
        #1 check("reset_async", 32'(respond), 32'h0);
        @(negedge clk);
        check("reset_held", 32'(respond), 32'h0);
        rst = 1'b0;

        // All requesting: plain rotation starting from requester 0.
        cycle(4'b1111, 4'b0001, "all_0");
        cycle(4'b1111, 4'b0010, "all_1");
        cycle(4'b1111, 4'b0100, "all_2");
        cycle(4'b1111, 4'b1000, "all_3");
        cycle(4'b1111, 4'b0001, "all_wrap");

        // Sole requester 2 granted every cycle; leaves ptr at 3.
        cycle(4'b0100, 4'b0100, "sole_0");
        cycle(4'b0100, 4'b0100, "sole_1");
        cycle(4'b0100, 4'b0100, "sole_2");

        // ptr = 3 with requesters 0 and 1.
        cycle(4'b0011, 4'b0001, "ptr3_0");
        cycle(4'b0011, 4'b0010, "ptr3_1");
        cycle(4'b0011, 4'b0001, "ptr3_2");

        // Idle keeps ptr at 1; resume continues from requester 1.
        for (int i = 0; i < 5; i++)
            cycle(4'b0000, 4'b0000, "idle");
        cycle(4'b1111, 4'b0010, "resume_0");
        cycle(4'b1111, 4'b0100, "resume_1");

        // Grant drops the cycle after the request goes away.
        cycle(4'b1000, 4'b1000, "drop_0");
        cycle(4'b0000, 4'b0000, "drop_1");

        // Mid-sequence async reset with ptr at 2; must restart from requester 0.
        cycle(4'b1111, 4'b0001, "pre_rst_0");
        cycle(4'b1111, 4'b0010, "pre_rst_1");
        #2 rst = 1'b1;
        #1 check("mid_rst_async", 32'(respond), 32'h0);
        @(negedge clk);
        check("mid_rst_held", 32'(respond), 32'h0);
        rst = 1'b0;
        cycle(4'b1111, 4'b0001, "post_rst_0");
        cycle(4'b1111, 4'b0010, "post_rst_1");

        // Randomized section, request pattern changes every 5 clocks.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        req_r = '0;
        for (int k = 0; k < N; k++)
            wait_c[k] = 0;
        for (int c = 0; c < 100; c++) begin
            if (c % 5 == 0)
                req_r = 4'($urandom_range(0, 15));
            request = req_r;
            prev    = req_r;
            exp_g   = '0;
            g       = -1;
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (g < 0 && prev[idx])
                    g = idx;
            end
            if (g >= 0) begin
                exp_g[g] = 1'b1;
                ptr_m    = (g + 1) % N;
            end
            @(posedge clk);
            @(negedge clk);
            check("rand_model", 32'(respond), 32'(exp_g));
            check("rand_onehot0", 32'($onehot0(respond)), 32'h1);
            check("rand_subset", 32'(respond & ~prev), 32'h0);
            max_wait = 0;
            for (int k = 0; k < N; k++) begin
                if (prev[k] && !respond[k])
                    wait_c[k]++;
                else
                    wait_c[k] = 0;
                if (wait_c[k] > max_wait)
                    max_wait = wait_c[k];
            end
            check("rand_starve", 32'(max_wait < N), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
